// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter: state
// encodings and a constant-evaluable ceil(log2) helper for index/counter widths.
package shared_reg_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    // ceil(log2(v)), never below 1 so every index/counter has at least one bit
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr.sv
// Combinational round-robin search: first asserted request at or after
// start_idx, wrapping mod N_REQ (valid for non-power-of-two N_REQ).
module rr_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned OWN_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OWN_W-1:0] start_idx,
    output logic             found_c,
    output logic [OWN_W-1:0] winner_c
);

    // Scan from the farthest offset down so the nearest hit is written last
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(start_idx) + i) % int'(N_REQ);
            if (req[OWN_W'(idx)]) begin
                found_c  = 1'b1;
                winner_c = OWN_W'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbitration with bounded bursts in front of a shared
// WIDTH-bit register; this block is the sole writer of that register.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 3,
    localparam int unsigned OWN_W    = clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [OWN_W-1:0]       owner,
    output logic [WIDTH-1:0]       q,
    output logic                   wr_valid
);

    localparam int unsigned BW = clog2(MAX_BURST + 1);

    logic [0:0]       state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [OWN_W-1:0] owner_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             wr_valid_nxt;
    logic [OWN_W-1:0] ptr, ptr_nxt;
    logic [BW-1:0]    burst_cnt, burst_nxt;

    logic [OWN_W-1:0] owner_inc_c;
    logic [OWN_W-1:0] search_start_c;
    logic             found_c;
    logic [OWN_W-1:0] winner_c;
    logic [N_REQ-1:0] owner_mask_c;
    logic             others_c;

    assign owner_inc_c    = (owner == OWN_W'(N_REQ - 1)) ? '0 : owner + OWN_W'(1);
    // Idle arbitration starts at ptr; a handoff starts just past the releasing owner
    assign search_start_c = (state == ST_OWNED) ? owner_inc_c : ptr;
    assign owner_mask_c   = N_REQ'(1) << owner;
    assign others_c       = |(req & ~owner_mask_c);

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req       (req),
        .start_idx (search_start_c),
        .found_c   (found_c),
        .winner_c  (winner_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            owner     <= '0;
            q         <= '0;
            wr_valid  <= 1'b0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            owner     <= owner_nxt;
            q         <= q_nxt;
            wr_valid  <= wr_valid_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = '0;
        owner_nxt    = owner;
        q_nxt        = q;
        wr_valid_nxt = 1'b0;
        ptr_nxt      = ptr;
        burst_nxt    = burst_cnt;

        case (state)
            ST_IDLE: begin
                if (found_c) begin
                    state_nxt          = ST_OWNED;
                    gnt_nxt[winner_c]  = 1'b1;
                    owner_nxt          = winner_c;
                    q_nxt              = wdata[int'(winner_c)*WIDTH +: WIDTH];
                    wr_valid_nxt       = 1'b1;
                    burst_nxt          = BW'(1);
                end
            end
            default: begin
                if (req[owner] && ((burst_cnt < BW'(MAX_BURST)) || !others_c)) begin
                    gnt_nxt      = gnt;
                    q_nxt        = wdata[int'(owner)*WIDTH +: WIDTH];
                    wr_valid_nxt = 1'b1;
                    burst_nxt    = (burst_cnt < BW'(MAX_BURST)) ? burst_cnt + BW'(1)
                                                                 : BW'(MAX_BURST);
                end else begin
                    ptr_nxt = owner_inc_c;
                    if (found_c) begin
                        gnt_nxt[winner_c] = 1'b1;
                        owner_nxt         = winner_c;
                        q_nxt             = wdata[int'(winner_c)*WIDTH +: WIDTH];
                        wr_valid_nxt      = 1'b1;
                        burst_nxt         = BW'(1);
                    end else begin
                        state_nxt = ST_IDLE;
                        burst_nxt = '0;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=3).
module tb_shared_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        wr_valid;

    int checks;
    int errors;

    shared_reg_arbiter #(
        .N_REQ     (4),
        .WIDTH     (8),
        .MAX_BURST (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .owner    (owner),
        .q        (q),
        .wr_valid (wr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int i, input logic [7:0] v);
        wdata[i*8 +: 8] = v;
    endtask

    task automatic check_owned(input string tag, input int o, input logic [7:0] qv);
        logic [3:0] oh;
        oh = 4'(1 << o);
        check({tag, "_gnt"}, 32'(gnt), 32'(oh));
        check({tag, "_owner"}, 32'(owner), 32'(o));
        check({tag, "_q"}, 32'(q), 32'(qv));
        check({tag, "_wr_valid"}, 32'(wr_valid), 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic [7:0] qv);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_q"}, 32'(q), 32'(qv));
        check({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        wdata  = '0;

        // Reset values hold before any clock edge
        #2;
        check_idle("reset", 8'h00);
        check("reset_owner", 32'(owner), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single one-cycle request from requester 2
        req = 4'b0100;
        set_w(2, 8'hA5);
        tick();
        check_owned("single", 2, 8'hA5);
        req = 4'b0000;
        tick();
        check_idle("single_release", 8'hA5);

        // Burst limit: requesters 0 and 1 alternate every 3 cycles (ptr=3 -> 0 first)
        set_w(0, 8'h10);
        set_w(1, 8'h20);
        req = 4'b0011;
        for (int k = 0; k < 7; k++) begin
            int o;
            o = (k / 3) % 2;
            tick();
            check_owned($sformatf("burst%0d", k), o, (o == 0) ? 8'h10 : 8'h20);
        end
        req = 4'b0000;
        tick();
        check_idle("burst_release", 8'h10);

        // Lone owner: requester 3 holds, q tracks its changing word
        req = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            set_w(3, 8'(8'h40 + k));
            tick();
            check_owned($sformatf("lone%0d", k), 3, 8'(8'h40 + k));
            check($sformatf("lone%0d_bcast", k), 32'(gnt), 32'h8);
        end
        req = 4'b0000;
        tick();
        check_idle("lone_release", 8'h49);

        // Round-robin wrap with all four requesting (ptr wrapped to 0)
        for (int i = 0; i < 4; i++) set_w(i, 8'(8'h30 + i));
        req = 4'b1111;
        for (int k = 0; k < 13; k++) begin
            int o;
            o = (k / 3) % 4;
            tick();
            check_owned($sformatf("rr%0d", k), o, 8'(8'h30 + o));
        end
        req = 4'b0000;
        tick();
        check_idle("rr_release", 8'h30);

        // Early release by owner 2 with 0 and 3 waiting: hand to 3, then 0
        req = 4'b0100;
        tick();
        check_owned("early_own2", 2, 8'h32);
        req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_owned($sformatf("early_h3_%0d", k), 3, 8'h33);
        end
        tick();
        check_owned("early_h0", 0, 8'h30);

        // Asynchronous reset mid-burst with all requests high
        req = 4'b1111;
        tick();
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst", 8'h00);
        check("async_rst_owner", 32'(owner), 32'd0);
        tick();
        check_idle("rst_held", 8'h00);
        rst = 1'b0;
        tick();
        check_owned("post_rst", 0, 8'h30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
